// File: rtl/ide_device_if.sv
// Host strobe/address lines and media port of the IDE device.
// The data bus stays a plain inout on the device; everything else is grouped here.
interface ide_device_if;
  logic        ide_dior;
  logic        ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;
  logic [23:0] media_lba;
  logic [7:0]  media_addr;
  logic        media_rd;
  logic        media_wr;
  logic [15:0] media_wdata;
  logic [15:0] media_rdata;
  logic        media_ready;

  modport slave (
    input  ide_dior, ide_diow, ide_cs, ide_da, media_rdata, media_ready,
    output media_lba, media_addr, media_rd, media_wr, media_wdata
  );
  modport master (
    output ide_dior, ide_diow, ide_cs, ide_da, media_rdata, media_ready,
    input  media_lba, media_addr, media_rd, media_wr, media_wdata
  );
endinterface

// File: rtl/ide_device.sv
// Single-sector PIO IDE device: taskfile, 256-word sector buffer,
// READ (0x20) / WRITE (0x30) sector commands staged through a media port.
module ide_device #(
  parameter int BUSY_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  inout  wire  [15:0]  ide_data_bus,
  ide_device_if.slave  bus
);
  localparam logic [4:0] A_DATA = 5'h10, A_ERR = 5'h11, A_SECCNT = 5'h12, A_SECNUM = 5'h13,
                         A_CYLLO = 5'h14, A_CYLHI = 5'h15, A_DRVHD = 5'h16, A_CMD = 5'h17,
                         A_DEVCTL = 5'h0E;
  localparam logic [15:0] BSY_LAST = 16'(BUSY_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_BUSY, S_FETCH, S_XFER_IN, S_XFER_OUT, S_FLUSH} state_t;
  state_t r_state, w_next;

  logic [1:0]  r_dior_s, r_diow_s;
  logic        r_dior_d, r_diow_d;
  logic [7:0]  r_feature, r_seccnt, r_secnum, r_cyllo, r_cylhi, r_drvhd, r_error, r_cmd;
  logic        r_err, r_nien, r_srst, r_rd_data, r_fetch_done, r_st_pend;
  logic [7:0]  r_ptr, r_maddr, r_st_addr;
  logic [15:0] r_bsy_cnt;
  logic [23:0] r_lba;
  logic [15:0] r_buf [256];

  logic        w_dior, w_diow, w_rd_ev, w_rd_end, w_wr_ev;
  logic [4:0]  w_addr;
  logic [15:0] w_wdata, w_rdata;
  logic [7:0]  w_status;
  logic        w_srst, w_cmd_wr, w_cmd_ok, w_data_wr, w_acc, w_wacc, w_unused;

  assign w_dior    = r_dior_s[1];
  assign w_diow    = r_diow_s[1];
  assign w_rd_ev   = !w_dior && r_dior_d;
  assign w_rd_end  = w_dior && !r_dior_d;
  assign w_wr_ev   = !w_diow && r_diow_d;
  assign w_addr    = {bus.ide_cs, bus.ide_da};
  assign w_wdata   = ide_data_bus;
  assign w_srst    = w_wr_ev && (w_addr == A_DEVCTL) && w_wdata[2];
  assign w_cmd_wr  = w_wr_ev && (w_addr == A_CMD) && (r_state == S_IDLE);
  assign w_cmd_ok  = ((w_wdata[7:0] == 8'h20) || (w_wdata[7:0] == 8'h30)) &&
                     (r_seccnt == 8'd1) && r_drvhd[6];
  assign w_data_wr = w_wr_ev && (w_addr == A_DATA) && (r_state == S_XFER_OUT);
  assign w_acc     = (r_state == S_FETCH) && !r_fetch_done && bus.media_ready;
  assign w_wacc    = (r_state == S_FLUSH) && bus.media_ready;
  assign w_unused  = ^{r_feature, r_nien, r_drvhd[7], r_drvhd[5:0]};

  assign bus.media_lba   = r_lba;
  assign bus.media_addr  = r_maddr;
  assign bus.media_rd    = (r_state == S_FETCH) && !r_fetch_done;
  assign bus.media_wr    = (r_state == S_FLUSH);
  assign bus.media_wdata = (r_state == S_FLUSH) ? r_buf[r_maddr] : 16'h0000;

  always_comb begin
    w_status = 8'h80;
    case (r_state)
      S_IDLE:                 w_status = {7'b0101000, r_err};
      S_XFER_IN, S_XFER_OUT:  w_status = 8'h58;
      default:                w_status = 8'h80;
    endcase
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (w_addr)
      A_DATA:          if (r_state == S_XFER_IN) w_rdata = r_buf[r_ptr];
      A_ERR:           w_rdata = {8'h00, r_error};
      A_SECCNT:        w_rdata = {8'h00, r_seccnt};
      A_SECNUM:        w_rdata = {8'h00, r_secnum};
      A_CYLLO:         w_rdata = {8'h00, r_cyllo};
      A_CYLHI:         w_rdata = {8'h00, r_cylhi};
      A_DRVHD:         w_rdata = {8'h00, r_drvhd};
      A_CMD, A_DEVCTL: w_rdata = {8'h00, w_status};
      default:         w_rdata = 16'h0000;
    endcase
  end

  // Synchronized dior doubles as the bus enable, so the bus floats in reset.
  assign ide_data_bus = w_dior ? 16'hzzzz : w_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_srst) w_next = S_BUSY;
    else begin
      case (r_state)
        S_IDLE:     if (w_cmd_wr && w_cmd_ok) w_next = S_BUSY;
        S_BUSY:     if (r_bsy_cnt == BSY_LAST)
                      w_next = r_srst ? S_IDLE : ((r_cmd == 8'h30) ? S_XFER_OUT : S_FETCH);
        S_FETCH:    if (r_st_pend && (r_st_addr == 8'hFF)) w_next = S_XFER_IN;
        S_XFER_IN:  if (w_rd_end && r_rd_data && (r_ptr == 8'hFF)) w_next = S_IDLE;
        S_XFER_OUT: if (w_data_wr && (r_ptr == 8'hFF)) w_next = S_FLUSH;
        S_FLUSH:    if (w_wacc && (r_maddr == 8'hFF)) w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dior_s <= 2'b11;  r_diow_s <= 2'b11;  r_dior_d <= 1'b1;  r_diow_d <= 1'b1;
      r_feature <= '0; r_seccnt <= '0; r_secnum <= '0; r_cyllo <= '0; r_cylhi <= '0;
      r_drvhd <= '0; r_error <= '0; r_cmd <= '0; r_err <= 1'b0; r_nien <= 1'b0;
      r_srst <= 1'b0; r_rd_data <= 1'b0; r_fetch_done <= 1'b0; r_st_pend <= 1'b0;
      r_ptr <= '0; r_maddr <= '0; r_st_addr <= '0; r_bsy_cnt <= '0; r_lba <= '0;
    end else begin
      r_dior_s  <= {r_dior_s[0], bus.ide_dior};
      r_diow_s  <= {r_diow_s[0], bus.ide_diow};
      r_dior_d  <= w_dior;
      r_diow_d  <= w_diow;
      // Media read data arrives one clock after acceptance; store it then.
      r_st_pend <= w_acc;
      r_st_addr <= r_maddr;
      if (w_rd_ev) r_rd_data <= (w_addr == A_DATA);
      if (w_wr_ev && (r_state == S_IDLE)) begin
        case (w_addr)
          A_ERR:    r_feature <= w_wdata[7:0];
          A_SECCNT: r_seccnt  <= w_wdata[7:0];
          A_SECNUM: r_secnum  <= w_wdata[7:0];
          A_CYLLO:  r_cyllo   <= w_wdata[7:0];
          A_CYLHI:  r_cylhi   <= w_wdata[7:0];
          A_DRVHD:  r_drvhd   <= w_wdata[7:0];
          default: ;
        endcase
      end
      if (w_wr_ev && (w_addr == A_DEVCTL)) r_nien <= w_wdata[1];
      if (w_cmd_wr) begin
        if (w_cmd_ok) begin
          r_err <= 1'b0;  r_error <= 8'h00;  r_srst <= 1'b0;
          r_cmd <= w_wdata[7:0];
          r_lba <= {r_cylhi, r_cyllo, r_secnum};
          r_ptr <= '0;  r_maddr <= '0;
        end else begin
          r_err <= 1'b1;  r_error <= 8'h04;
        end
      end
      if (w_srst) r_bsy_cnt <= '0;
      else if (r_state == S_BUSY) r_bsy_cnt <= r_bsy_cnt + 16'd1;
      else r_bsy_cnt <= '0;
      if (w_srst) begin
        r_err <= 1'b0;  r_srst <= 1'b1;  r_ptr <= '0;  r_maddr <= '0;  r_fetch_done <= 1'b0;
      end else begin
        if ((r_state == S_XFER_IN) && w_rd_end && r_rd_data) r_ptr <= r_ptr + 8'd1;
        if (w_data_wr) r_ptr <= r_ptr + 8'd1;
        if (w_acc || w_wacc) r_maddr <= r_maddr + 8'd1;
        if (w_acc && (r_maddr == 8'hFF)) r_fetch_done <= 1'b1;
        else if (r_state != S_FETCH)     r_fetch_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_st_pend)                r_buf[r_st_addr] <= bus.media_rdata;
    else if (w_data_wr && !w_srst) r_buf[r_ptr]    <= w_wdata;
  end
endmodule

// File: tb/tb_ide_device.sv
// Scoreboard bench for ide_device: host tasks push expectations, a host-read monitor
// and a media monitor pop and compare against what the device presents.
module tb_ide_device;
  localparam int BC = 16;
  localparam logic [4:0] A_DATA = 5'h10, A_ERR = 5'h11, A_SECCNT = 5'h12, A_SECNUM = 5'h13,
                         A_CYLLO = 5'h14, A_CYLHI = 5'h15, A_DRVHD = 5'h16, A_CMD = 5'h17,
                         A_DEVCTL = 5'h0E;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wire  [15:0] ide_data_bus;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dout = 16'h0000;
  assign ide_data_bus = tb_drv ? tb_dout : 16'hzzzz;

  ide_device_if bus ();
  ide_device #(.BUSY_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .ide_data_bus(ide_data_bus), .bus(bus)
  );

  typedef struct { logic [4:0] a; logic [15:0] d; } rd_t;
  typedef struct { logic [7:0] a; logic [15:0] d; logic [23:0] lba; } mw_t;
  rd_t q_rd [$];
  mw_t q_mrd [$];
  mw_t q_mwr [$];
  int  n_tests = 0;
  int  n_fail  = 0;
  event rd_sample;
  bit   toggle_en = 1'b0;
  logic [3:0] tog_pat = 4'b1001;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [15:0] pat(logic [23:0] lba, logic [7:0] a);
    return lba[15:0] ^ {a, ~a};
  endfunction

  task automatic hwrite(logic [4:0] a, logic [15:0] d);
    @(negedge clk);
    bus.ide_cs = a[4:3];  bus.ide_da = a[2:0];
    tb_dout = d;  tb_drv = 1'b1;  bus.ide_diow = 1'b0;
    repeat (3) @(negedge clk);
    bus.ide_diow = 1'b1;
    repeat (2) @(negedge clk);
    tb_drv = 1'b0;
  endtask

  task automatic hread(logic [4:0] a, logic [15:0] exp);
    @(negedge clk);
    bus.ide_cs = a[4:3];  bus.ide_da = a[2:0];
    q_rd.push_back('{a, exp});
    bus.ide_dior = 1'b0;
    repeat (3) @(negedge clk);
    -> rd_sample;
    bus.ide_dior = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic setup_lba(logic [23:0] lba);
    hwrite(A_SECCNT, 16'h0001);
    hwrite(A_SECNUM, {8'h00, lba[7:0]});
    hwrite(A_CYLLO,  {8'h00, lba[15:8]});
    hwrite(A_CYLHI,  {8'h00, lba[23:16]});
    hwrite(A_DRVHD,  16'h0040);
  endtask

  task automatic wait_drain(bit wr, string name);
    int n = 0;
    while (((wr ? q_mwr.size() : q_mrd.size()) != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, wr ? q_mwr.size() : q_mrd.size(), 0);
  endtask

  // Host read monitor
  initial begin
    rd_t r;
    forever begin
      @(rd_sample);
      if (q_rd.size() == 0) flag("host read with no expectation");
      else begin
        r = q_rd.pop_front();
        check($sformatf("read reg %02h", r.a), {16'h0, ide_data_bus}, {16'h0, r.d});
      end
    end
  end

  // Media model and media-side monitor
  initial begin
    bit          pend = 1'b0;
    logic [15:0] pdata = 16'h0;
    int          idx = 0;
    mw_t         e;
    bus.media_ready = 1'b1;
    bus.media_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (pend) bus.media_rdata = pdata;
      bus.media_ready = toggle_en ? tog_pat[idx] : 1'b1;
      idx = (idx + 1) % 4;
      pend = bus.media_rd && bus.media_ready;
      if (pend) begin
        pdata = pat(bus.media_lba, bus.media_addr);
        if (q_mrd.size() == 0) flag("unexpected media_rd");
        else begin
          e = q_mrd.pop_front();
          check("media_rd addr", {24'h0, bus.media_addr}, {24'h0, e.a});
          check("media_rd lba", {8'h0, bus.media_lba}, {8'h0, e.lba});
        end
      end
      if (bus.media_wr && bus.media_ready) begin
        if (q_mwr.size() == 0) flag("unexpected media_wr");
        else begin
          e = q_mwr.pop_front();
          check("media_wr addr", {24'h0, bus.media_addr}, {24'h0, e.a});
          check("media_wr data", {16'h0, bus.media_wdata}, {16'h0, e.d});
          check("media_wr lba", {8'h0, bus.media_lba}, {8'h0, e.lba});
        end
      end
    end
  end

  task automatic read_sector(logic [23:0] lba, bit tog);
    toggle_en = tog;
    setup_lba(lba);
    for (int i = 0; i < 256; i++) q_mrd.push_back('{8'(i), 16'h0, lba});
    hwrite(A_CMD, 16'h0020);
    hread(A_CMD, 16'h0080);
    hread(A_ERR, 16'h0000);
    wait_drain(1'b0, "fetch drain");
    hread(A_CMD, 16'h0058);
    for (int i = 0; i < 256; i++) hread(A_DATA, pat(lba, 8'(i)));
    hread(A_CMD, 16'h0050);
    toggle_en = 1'b0;
  endtask

  task automatic write_sector(logic [23:0] lba, bit tog, logic [15:0] k, logic [15:0] x);
    toggle_en = tog;
    setup_lba(lba);
    for (int i = 0; i < 256; i++) q_mwr.push_back('{8'(i), 16'(i) * k ^ x, lba});
    hwrite(A_CMD, 16'h0030);
    repeat (BC + 4) @(negedge clk);
    hread(A_CMD, 16'h0058);
    for (int i = 0; i < 256; i++) hwrite(A_DATA, 16'(i) * k ^ x);
    wait_drain(1'b1, "flush drain");
    hread(A_CMD, 16'h0050);
    toggle_en = 1'b0;
  endtask

  initial begin
    bus.ide_dior = 1'b1;  bus.ide_diow = 1'b1;  bus.ide_cs = 2'b00;  bus.ide_da = 3'b000;
    repeat (3) @(negedge clk);
    check("reset media_rd", {31'h0, bus.media_rd}, 0);
    check("reset media_wr", {31'h0, bus.media_wr}, 0);
    check("reset media_lba", {8'h0, bus.media_lba}, 0);
    check("reset media_addr", {24'h0, bus.media_addr}, 0);
    check("reset media_wdata", {16'h0, bus.media_wdata}, 0);
    reset = 1'b1;
    hread(A_CMD, 16'h0050);
    hread(A_DEVCTL, 16'h0050);
    hread(A_ERR, 16'h0000);
    hread(A_SECCNT, 16'h0000);
    hread(A_DATA, 16'h0000);

    read_sector(24'h001234, 1'b0);
    write_sector(24'h000005, 1'b0, 16'd3, 16'h0000);

    hwrite(A_CMD, 16'h00EC);
    hread(A_CMD, 16'h0051);
    hread(A_ERR, 16'h0004);
    read_sector(24'h00ABCD, 1'b1);
    write_sector(24'h000007, 1'b1, 16'd7, 16'h8000);

    // Soft reset in the middle of a host write sector
    setup_lba(24'h000007);
    hwrite(A_CMD, 16'h0030);
    repeat (BC + 4) @(negedge clk);
    hread(A_CMD, 16'h0058);
    for (int i = 0; i < 10; i++) hwrite(A_DATA, 16'hBEEF);
    hwrite(A_DEVCTL, 16'h0004);
    hread(A_CMD, 16'h0080);
    repeat (BC) @(negedge clk);
    hread(A_CMD, 16'h0050);
    hread(A_DEVCTL, 16'h0050);
    hwrite(A_DEVCTL, 16'h0000);

    // Hard reset at host word 100 of a read sector
    setup_lba(24'h001234);
    for (int i = 0; i < 256; i++) q_mrd.push_back('{8'(i), 16'h0, 24'h001234});
    hwrite(A_CMD, 16'h0020);
    wait_drain(1'b0, "fetch drain 2");
    hread(A_CMD, 16'h0058);
    for (int i = 0; i < 100; i++) hread(A_DATA, pat(24'h001234, 8'(i)));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-xfer reset media_rd", {31'h0, bus.media_rd}, 0);
    check("mid-xfer reset media_wr", {31'h0, bus.media_wr}, 0);
    check("mid-xfer reset media_lba", {8'h0, bus.media_lba}, 0);
    reset = 1'b1;
    hread(A_CMD, 16'h0050);
    hread(A_DATA, 16'h0000);
    hread(A_SECCNT, 16'h0000);
    repeat (20) @(negedge clk);

    check("host reads left", q_rd.size(), 0);
    check("media reads left", q_mrd.size(), 0);
    check("media writes left", q_mwr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
